// File: rtl/axis_pkt_rr_arbiter_pkg.sv
// Shared widths, tuser field bounds and FSM encodings for the packet round-robin arbiter.
package axis_pkt_rr_arbiter_pkg;

    localparam int DATA_W  = 256;
    localparam int KEEP_W  = 32;
    localparam int TUSER_W = 128;

    localparam int SRC_PORT_LO = 16;
    localparam int SRC_PORT_HI = 23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ARB  = 2'b01,
        ST_PKT  = 2'b10
    } arb_state_e;

    // Port i is marked by bit 2*i of the 8-bit source field.
    function automatic logic [7:0] src_onehot(input logic [1:0] port);
        src_onehot = 8'b0000_0001 << {port, 1'b0};
    endfunction

endpackage

// File: rtl/axis_pkt_rr_arbiter_rr_pick4.sv
// Combinational 4-way round-robin pick: first requester after last_grant, wrapping.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last_grant,
    output logic [1:0] grant,
    output logic       found
);

    logic [1:0] idx;

    // Scan farthest-first so the nearest requester after last_grant is written last and wins.
    always_comb begin
        grant = last_grant;
        found = 1'b0;
        idx   = last_grant;
        for (int k = 4; k >= 1; k--) begin
            idx = last_grant + k[1:0];
            if (req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Four-to-one AXIS packet arbiter: grant locked from first beat to tlast, registered egress stage.
module axis_pkt_rr_arbiter
    import axis_pkt_rr_arbiter_pkg::*;
#(
    parameter int NPORTS    = 4,
    parameter bit SRC_STAMP = 1'b1
) (
    input  logic                        arb_aclk,
    input  logic                        arb_arstn,
    input  logic                        arb_en,
    input  logic [NPORTS-1:0]           arb_mask,
    input  logic [NPORTS-1:0]           arb_avalid,
    output logic [NPORTS-1:0]           arb_aready,
    input  logic [NPORTS*DATA_W-1:0]    arb_adata,
    input  logic [NPORTS*KEEP_W-1:0]    arb_akeep,
    input  logic [NPORTS-1:0]           arb_atlast,
    input  logic [NPORTS*TUSER_W-1:0]   arb_atuser,
    output logic                        arb_bvalid,
    input  logic                        arb_bready,
    output logic [DATA_W-1:0]           arb_bdata,
    output logic [KEEP_W-1:0]           arb_bkeep,
    output logic                        arb_btlast,
    output logic [TUSER_W-1:0]          arb_btuser,
    output logic [1:0]                  dbg_state,
    output logic [1:0]                  dbg_grant
);

    arb_state_e          state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic [1:0]          last_grant_q, last_grant_d;
    logic                bvalid_q, bvalid_d;
    logic [DATA_W-1:0]   bdata_q, bdata_d;
    logic [KEEP_W-1:0]   bkeep_q, bkeep_d;
    logic                btlast_q, btlast_d;
    logic [TUSER_W-1:0]  btuser_q, btuser_d;

    logic [NPORTS-1:0]   req;
    logic [1:0]          pick;
    logic                pick_found;
    logic                sel_valid;
    logic                sel_last;
    logic                out_free;
    logic                accept;
    logic [DATA_W-1:0]   sel_data;
    logic [KEEP_W-1:0]   sel_keep;
    logic [TUSER_W-1:0]  sel_user;
    logic [TUSER_W-1:0]  sel_user_st;

    assign req = arb_avalid & arb_mask & {NPORTS{arb_en}};

    rr_pick4 u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (pick),
        .found      (pick_found)
    );

    assign sel_valid = arb_avalid[grant_q];
    assign sel_last  = arb_atlast[grant_q];
    assign sel_data  = arb_adata[int'(grant_q)*DATA_W +: DATA_W];
    assign sel_keep  = arb_akeep[int'(grant_q)*KEEP_W +: KEEP_W];
    assign sel_user  = arb_atuser[int'(grant_q)*TUSER_W +: TUSER_W];

    // The output register can take a beat when empty or draining this cycle.
    assign out_free = ~bvalid_q | arb_bready;
    assign accept   = (state_q == ST_PKT) & sel_valid & out_free;

    always_comb begin
        arb_aready = '0;
        if (state_q == ST_PKT) begin
            arb_aready[grant_q] = out_free;
        end
    end

    always_comb begin
        sel_user_st = sel_user;
        if (SRC_STAMP) begin
            sel_user_st[SRC_PORT_HI:SRC_PORT_LO] = src_onehot(grant_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (pick_found) begin
                    grant_d = pick;
                    state_d = ST_PKT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PKT: begin
                // Enable and mask are not consulted here, so a packet always runs to tlast.
                if (accept && sel_last) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bvalid_d = bvalid_q;
        bdata_d  = bdata_q;
        bkeep_d  = bkeep_q;
        btlast_d = btlast_q;
        btuser_d = btuser_q;
        if (accept) begin
            bvalid_d = 1'b1;
            bdata_d  = sel_data;
            bkeep_d  = sel_keep;
            btlast_d = sel_last;
            btuser_d = sel_user_st;
        end else if (arb_bready) begin
            bvalid_d = 1'b0;
        end
    end

    always_ff @(posedge arb_aclk or negedge arb_arstn) begin
        if (!arb_arstn) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd3;
            bvalid_q     <= 1'b0;
            bdata_q      <= '0;
            bkeep_q      <= '0;
            btlast_q     <= 1'b0;
            btuser_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            bvalid_q     <= bvalid_d;
            bdata_q      <= bdata_d;
            bkeep_q      <= bkeep_d;
            btlast_q     <= btlast_d;
            btuser_q     <= btuser_d;
        end
    end

    assign arb_bvalid = bvalid_q;
    assign arb_bdata  = bdata_q;
    assign arb_bkeep  = bkeep_q;
    assign arb_btlast = btlast_q;
    assign arb_btuser = btuser_q;
    assign dbg_state  = state_q;
    assign dbg_grant  = grant_q;

endmodule
